// File: rtl/lcd_sprite_overlay.sv
`default_nettype none
// ============================================================================
// Module   : lcd_sprite_overlay
// Function : Recovers x/y from DE/VSYNC and paints a bouncing solid box over
//            the RGB565 stream. Timing and pixels are delayed by 2 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_sprite_overlay #(
    parameter int          H_ACTIVE = 480,
    parameter int          V_ACTIVE = 272,
    parameter int          BOX_W    = 32,
    parameter int          BOX_H    = 32,
    parameter int          STEP     = 2,
    parameter logic [15:0] FG_COLOR = 16'hFFFF
) (
    input  logic        PixelClk,
    input  logic        ARST_N,
    input  logic        IN_DE,
    input  logic        IN_HSYNC,
    input  logic        IN_VSYNC,
    input  logic [4:0]  IN_R,
    input  logic [5:0]  IN_G,
    input  logic [4:0]  IN_B,
    input  logic        MOVE_EN,
    input  logic        SHOW,
    output logic        OUT_DE,
    output logic        OUT_HSYNC,
    output logic        OUT_VSYNC,
    output logic [4:0]  OUT_R,
    output logic [5:0]  OUT_G,
    output logic [4:0]  OUT_B,
    output logic [11:0] BOX_X,
    output logic [11:0] BOX_Y,
    output logic        FRAME_TICK
);

    localparam logic [12:0] c_X_MAX = 13'(H_ACTIVE - BOX_W);
    localparam logic [12:0] c_Y_MAX = 13'(V_ACTIVE - BOX_H);
    localparam logic [12:0] c_STEP  = 13'(STEP);
    localparam logic [12:0] c_BW    = 13'(BOX_W);
    localparam logic [12:0] c_BH    = 13'(BOX_H);

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_X      = 2'd1;
    localparam logic [1:0] S_Y      = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic        r_de1, r_hs1, r_vs1;
    logic [15:0] r_rgb1;
    logic [11:0] r_x_cnt, r_y_cnt;
    logic [11:0] r_box_x, r_box_y, r_nx, r_ny;
    logic        r_dx_neg, r_dy_neg;
    logic [1:0]  r_state, w_state_nxt;
    logic        w_vs_fall, w_de_fall, w_hit;
    logic [12:0] w_nx, w_ny;
    logic        w_dx_neg_nxt, w_dy_neg_nxt;

    assign w_vs_fall = r_vs1 & ~IN_VSYNC;
    assign w_de_fall = r_de1 & ~IN_DE;

    // Counters sit beside the stage-1 registers, so they name the pixel in r_rgb1.
    always_ff @(posedge PixelClk or negedge ARST_N) begin
        if (!ARST_N) begin
            r_de1   <= 1'b0;
            r_hs1   <= 1'b1;
            r_vs1   <= 1'b1;
            r_rgb1  <= 16'h0000;
            r_x_cnt <= 12'd0;
            r_y_cnt <= 12'd0;
        end else begin
            r_de1  <= IN_DE;
            r_hs1  <= IN_HSYNC;
            r_vs1  <= IN_VSYNC;
            r_rgb1 <= {IN_R, IN_G, IN_B};
            if (IN_DE && r_de1)
                r_x_cnt <= (r_x_cnt == 12'hFFF) ? r_x_cnt : r_x_cnt + 12'd1;
            else
                r_x_cnt <= 12'd0;
            if (w_vs_fall)
                r_y_cnt <= 12'd0;
            else if (w_de_fall && r_y_cnt != 12'hFFF)
                r_y_cnt <= r_y_cnt + 12'd1;
        end
    end

    assign w_hit = SHOW && r_de1 &&
                   ({1'b0, r_x_cnt} >= {1'b0, r_box_x}) &&
                   ({1'b0, r_x_cnt} <  {1'b0, r_box_x} + c_BW) &&
                   ({1'b0, r_y_cnt} >= {1'b0, r_box_y}) &&
                   ({1'b0, r_y_cnt} <  {1'b0, r_box_y} + c_BH);

    always_ff @(posedge PixelClk or negedge ARST_N) begin
        if (!ARST_N) begin
            OUT_DE    <= 1'b0;
            OUT_HSYNC <= 1'b1;
            OUT_VSYNC <= 1'b1;
            {OUT_R, OUT_G, OUT_B} <= 16'h0000;
        end else begin
            OUT_DE    <= r_de1;
            OUT_HSYNC <= r_hs1;
            OUT_VSYNC <= r_vs1;
            if (w_hit)
                {OUT_R, OUT_G, OUT_B} <= FG_COLOR;
            else if (r_de1)
                {OUT_R, OUT_G, OUT_B} <= r_rgb1;
            else
                {OUT_R, OUT_G, OUT_B} <= 16'h0000;
        end
    end

    always_comb begin
        w_nx         = {1'b0, r_box_x} + c_STEP;
        w_dx_neg_nxt = r_dx_neg;
        if (!r_dx_neg) begin
            if ({1'b0, r_box_x} + c_STEP >= c_X_MAX) begin
                w_nx         = c_X_MAX;
                w_dx_neg_nxt = 1'b1;
            end
        end else if ({1'b0, r_box_x} <= c_STEP) begin
            w_nx         = 13'd0;
            w_dx_neg_nxt = 1'b0;
        end else begin
            w_nx = {1'b0, r_box_x} - c_STEP;
        end
    end

    always_comb begin
        w_ny         = {1'b0, r_box_y} + c_STEP;
        w_dy_neg_nxt = r_dy_neg;
        if (!r_dy_neg) begin
            if ({1'b0, r_box_y} + c_STEP >= c_Y_MAX) begin
                w_ny         = c_Y_MAX;
                w_dy_neg_nxt = 1'b1;
            end
        end else if ({1'b0, r_box_y} <= c_STEP) begin
            w_ny         = 13'd0;
            w_dy_neg_nxt = 1'b0;
        end else begin
            w_ny = {1'b0, r_box_y} - c_STEP;
        end
    end

    always_ff @(posedge PixelClk or negedge ARST_N) begin
        if (!ARST_N)
            r_state <= S_WAIT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT:   if (w_vs_fall && MOVE_EN) w_state_nxt = S_X;
            S_X:      w_state_nxt = S_Y;
            S_Y:      w_state_nxt = S_COMMIT;
            default:  w_state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        FRAME_TICK = (r_state == S_COMMIT);
    end

    // Position only changes at commit, which falls inside vertical blanking.
    always_ff @(posedge PixelClk or negedge ARST_N) begin
        if (!ARST_N) begin
            r_box_x  <= 12'd0;
            r_box_y  <= 12'd0;
            r_nx     <= 12'd0;
            r_ny     <= 12'd0;
            r_dx_neg <= 1'b0;
            r_dy_neg <= 1'b0;
        end else begin
            case (r_state)
                S_X: begin
                    r_nx     <= w_nx[11:0];
                    r_dx_neg <= w_dx_neg_nxt;
                end
                S_Y: begin
                    r_ny     <= w_ny[11:0];
                    r_dy_neg <= w_dy_neg_nxt;
                end
                S_COMMIT: begin
                    r_box_x <= r_nx;
                    r_box_y <= r_ny;
                end
                default: ;
            endcase
        end
    end

    assign BOX_X = r_box_x;
    assign BOX_Y = r_box_y;

endmodule
`default_nettype wire
